// File: rtl/draw_pkg.sv
// Drawing-stage geometry shared by the sprite drawers and the gloves
// position controller.
//   GLOVES_LENGTH / GLOVES_WIDTH : gloves sprite size in pixels (x / y)
//   GOAL_*                       : goal area the gloves must stay inside
package draw_pkg;

    localparam int GLOVES_LENGTH = 100;
    localparam int GLOVES_WIDTH  = 100;

    localparam int GOAL_X_MIN = 112;
    localparam int GOAL_X_MAX = 912;
    localparam int GOAL_Y_MIN = 150;
    localparam int GOAL_Y_MAX = 500;

endpackage

// File: rtl/game_pkg.sv
// Game-level types shared between the keeper controllers and game logic.
//   gloves_state_t : keeper gloves control state
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        DIVE    = 2'd2,
        RECOVER = 2'd3
    } gloves_state_t;

endpackage

// File: rtl/pos_step_limiter.sv
// Single-axis gloves position helper (purely combinational).
// Converts a raw mouse coordinate into a clamped top-left target and
// computes the next position one slew-limited step toward a target.
//   raw_pos     : raw mouse coordinate
//   cur_pos     : current gloves position (always inside [MIN, MAX])
//   hold_target : previously latched target, used when use_hold is set
//   use_hold    : step toward hold_target instead of the live target
//   step        : maximum movement for this frame
//   live_target : raw_pos - OFFSET clamped to [MIN, MAX]
//   next_pos    : cur_pos moved at most step toward the selected target
module pos_step_limiter #(
    parameter int MIN    = 0,
    parameter int MAX    = 4095,
    parameter int OFFSET = 0
) (
    input  logic [11:0] raw_pos,
    input  logic [11:0] cur_pos,
    input  logic [11:0] hold_target,
    input  logic        use_hold,
    input  logic [11:0] step,
    output logic [11:0] live_target,
    output logic [11:0] next_pos
);

    localparam logic signed [13:0] MIN_S    = 14'(MIN);
    localparam logic signed [13:0] MAX_S    = 14'(MAX);
    localparam logic signed [13:0] OFFSET_S = 14'(OFFSET);

    logic signed [13:0] raw_off;
    logic        [11:0] tgt;
    logic        [11:0] diff;

    // Offset is applied in a wider signed domain so a small raw value
    // produces a negative result (clamped to MIN) instead of wrapping.
    assign raw_off = $signed({2'b00, raw_pos}) - OFFSET_S;

    always_comb begin
        if (raw_off < MIN_S) begin
            live_target = 12'(MIN);
        end else if (raw_off > MAX_S) begin
            live_target = 12'(MAX);
        end else begin
            live_target = raw_pos - 12'(OFFSET);
        end
    end

    // Both target and position lie inside [MIN, MAX], so unsigned 12-bit
    // arithmetic on the ordered difference cannot wrap.
    always_comb begin
        tgt      = use_hold ? hold_target : live_target;
        diff     = 12'd0;
        next_pos = tgt;
        if (tgt > cur_pos) begin
            diff = tgt - cur_pos;
            if (diff > step) begin
                next_pos = cur_pos + step;
            end
        end else begin
            diff = cur_pos - tgt;
            if (diff > step) begin
                next_pos = cur_pos - step;
            end
        end
    end

endmodule

// File: rtl/gloves_ctl.sv
// Frame-synchronous goalkeeper gloves position controller.
// Turns raw mouse coordinates into a centred, goal-clamped, slew-limited
// gloves top-left position, with a dive/recover sequence on left click.
// Everything updates only on the vblnk rising edge so the sprite never
// tears mid-frame.
//   clk, rst     : pixel clock, synchronous active-high reset
//   enable       : keeper round active
//   mouse_xpos/ypos, mouse_left : raw mouse state
//   vblnk        : vertical blank from the timing chain
//   xpos, ypos   : gloves top-left position to the drawing stage
//   dive_active  : high while the gloves are diving
module gloves_ctl
    import game_pkg::*;
#(
    parameter int GOAL_X_MIN     = draw_pkg::GOAL_X_MIN,
    parameter int GOAL_X_MAX     = draw_pkg::GOAL_X_MAX,
    parameter int GOAL_Y_MIN     = draw_pkg::GOAL_Y_MIN,
    parameter int GOAL_Y_MAX     = draw_pkg::GOAL_Y_MAX,
    parameter int MAX_STEP       = 8,
    parameter int DIVE_STEP      = 24,
    parameter int DIVE_FRAMES    = 10,
    parameter int RECOVER_FRAMES = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        vblnk,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        dive_active
);

    localparam int GL = draw_pkg::GLOVES_LENGTH;
    localparam int GW = draw_pkg::GLOVES_WIDTH;

    localparam int X_MAX  = GOAL_X_MAX - GL;
    localparam int Y_MAX  = GOAL_Y_MAX - GW;
    localparam int HOME_X = (GOAL_X_MIN + GOAL_X_MAX - GL) / 2;
    localparam int HOME_Y = GOAL_Y_MAX - GW;

    localparam int CNT_MAX = (DIVE_FRAMES > RECOVER_FRAMES) ? DIVE_FRAMES : RECOVER_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    gloves_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [11:0]        xpos_q, xpos_d;
    logic [11:0]        ypos_q, ypos_d;
    logic [11:0]        dive_tx_q, dive_tx_d;
    logic [11:0]        dive_ty_q, dive_ty_d;
    logic               dive_active_q, dive_active_d;
    logic               vblnk_prev_q, vblnk_prev_d;
    logic               left_prev_q, left_prev_d;
    logic               press_pending_q, press_pending_d;

    logic               frame_tick;
    logic               press;
    logic               press_now;
    logic               in_dive;
    logic [11:0]        step;
    logic [11:0]        live_tx, live_ty;
    logic [11:0]        next_x, next_y;

    assign in_dive = (state_q == DIVE);
    assign step    = in_dive ? 12'(DIVE_STEP) : 12'(MAX_STEP);

    pos_step_limiter #(
        .MIN    (GOAL_X_MIN),
        .MAX    (X_MAX),
        .OFFSET (GL / 2)
    ) u_x_limiter (
        .raw_pos     (mouse_xpos),
        .cur_pos     (xpos_q),
        .hold_target (dive_tx_q),
        .use_hold    (in_dive),
        .step        (step),
        .live_target (live_tx),
        .next_pos    (next_x)
    );

    pos_step_limiter #(
        .MIN    (GOAL_Y_MIN),
        .MAX    (Y_MAX),
        .OFFSET (GW / 2)
    ) u_y_limiter (
        .raw_pos     (mouse_ypos),
        .cur_pos     (ypos_q),
        .hold_target (dive_ty_q),
        .use_hold    (in_dive),
        .step        (step),
        .live_target (live_ty),
        .next_pos    (next_y)
    );

    always_comb begin
        frame_tick = vblnk & ~vblnk_prev_q;
        press      = mouse_left & ~left_prev_q;
        // A press landing on the tick cycle itself is still honoured.
        press_now  = press_pending_q | press;

        vblnk_prev_d    = vblnk;
        left_prev_d     = mouse_left;
        press_pending_d = frame_tick ? 1'b0 : press_now;

        state_d   = state_q;
        cnt_d     = cnt_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        dive_tx_d = dive_tx_q;
        dive_ty_d = dive_ty_q;

        if (frame_tick) begin
            if (!enable) begin
                state_d = IDLE;
                cnt_d   = '0;
                xpos_d  = 12'(HOME_X);
                ypos_d  = 12'(HOME_Y);
            end else begin
                case (state_q)
                    IDLE: begin
                        xpos_d  = 12'(HOME_X);
                        ypos_d  = 12'(HOME_Y);
                        state_d = TRACK;
                    end
                    TRACK: begin
                        // The tick that starts a dive still moves at tracking speed.
                        xpos_d = next_x;
                        ypos_d = next_y;
                        if (press_now) begin
                            dive_tx_d = live_tx;
                            dive_ty_d = live_ty;
                            cnt_d     = CNT_W'(DIVE_FRAMES - 1);
                            state_d   = DIVE;
                        end
                    end
                    DIVE: begin
                        xpos_d = next_x;
                        ypos_d = next_y;
                        if (cnt_q == '0) begin
                            cnt_d   = CNT_W'(RECOVER_FRAMES - 1);
                            state_d = RECOVER;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    RECOVER: begin
                        if (cnt_q == '0) begin
                            state_d = TRACK;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end

        dive_active_d = (state_d == DIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            xpos_q          <= 12'(HOME_X);
            ypos_q          <= 12'(HOME_Y);
            dive_tx_q       <= 12'(HOME_X);
            dive_ty_q       <= 12'(HOME_Y);
            dive_active_q   <= 1'b0;
            vblnk_prev_q    <= 1'b0;
            left_prev_q     <= 1'b0;
            press_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            xpos_q          <= xpos_d;
            ypos_q          <= ypos_d;
            dive_tx_q       <= dive_tx_d;
            dive_ty_q       <= dive_ty_d;
            dive_active_q   <= dive_active_d;
            vblnk_prev_q    <= vblnk_prev_d;
            left_prev_q     <= left_prev_d;
            press_pending_q <= press_pending_d;
        end
    end

    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign dive_active = dive_active_q;

endmodule
